axi_lite_dbg_master: RTL and testbench
======================================

// Module: axi_lite_dbg_master
// PURPOSE
//  AXI4-Lite initiator for single-beat debug register accesses (32-bit addr/data).
//  Converts a valid/ready command into one AXI-Lite read or write, then returns the
//  data and response on a valid/ready response port. Drives register slaves such as
//  the debug register block and soft-reset control from test or bring-up logic.
//  Single outstanding transaction; a watchdog bounds every wait.
// PARAMETERS
//  TMO_W     16      width of the watchdog counter
//  TMO_LIMIT 16'hFFFF  cycles waited in any AXI phase before the access is abandoned
// PORTS
//  axi_clk      in   1   clock
//  axi_aresetn  in   1   asynchronous active-low reset
//  cmd_valid    in   1   command request
//  cmd_ready    out  1   command accepted (high only in IDLE)
//  cmd_wr       in   1   1=write, 0=read
//  cmd_addr     in   32  byte address
//  cmd_wdata    in   32  write data (ignored on reads)
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   response consumed
//  rsp_rdata    out  32  read data (0 for writes and timeouts)
//  rsp_resp     out  2   BRESP/RRESP captured; 2'b10 on timeout
//  rsp_timeout  out  1   access abandoned by the watchdog
//  m_axi_awvalid/awready/awaddr[31:0]   out/in/out   write address channel
//  m_axi_wvalid/wready/wdata[31:0]      out/in/out   write data channel, wstrb fixed 4'hF
//  m_axi_bvalid/bready/bresp[1:0]       in/out/in    write response channel
//  m_axi_arvalid/arready/araddr[31:0]   out/in/out   read address channel
//  m_axi_rvalid/rready/rdata[31:0]/rresp[1:0]  in/out/in/in  read data channel
// BEHAVIOUR
//  Reset: state IDLE; every valid, ready and rsp_* output 0; address/data registers 0.
//  Registered outputs only; no combinational path from AXI inputs to AXI outputs.
//  States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
//  IDLE: cmd_ready=1; on cmd_valid latch addr/wdata; wr -> WR_REQ, else -> RD_REQ.
//   AXI valids are asserted on the next cycle (1-cycle command-to-valid latency).
//  WR_REQ: awvalid and wvalid asserted together. Each drops on its own handshake
//   (aw_done/w_done flags); both may complete in the same or different cycles.
//   Valid is never withdrawn before its handshake except on timeout.
//   Both done -> WR_RESP with bready=1.
//  WR_RESP: on bvalid capture bresp, bready->0, go to RSP.
//  RD_REQ: arvalid=1 until arready, then RD_DATA with rready=1.
//  RD_DATA: on rvalid capture rdata/rresp, rready->0, go to RSP.
//  RSP: rsp_valid=1, payload stable until rsp_ready; handshake -> IDLE, rsp_valid=0.
//   Back-to-back minimum: IDLE cycle between accesses (cmd_ready low in RSP).
//  Watchdog: counter clears on every state change and counts in WR_REQ, WR_RESP,
//   RD_REQ and RD_DATA. At count==TMO_LIMIT it drops all valids and readies, sets
//   rsp_resp=2'b10, rsp_timeout=1, rdata=0, and goes to RSP.
//   A handshake in the same cycle as expiry wins; the timeout does not fire.
//   The counter saturates and never wraps.
//   A late bvalid or rvalid after an abort is ignored: bready/rready stay 0.
//  Exactly one of bvalid/rvalid is expected per state; the other channel is ignored.
//  Async reset mid-transaction: immediate return to IDLE with all outputs 0.
//   Any in-flight access is lost without a response.
// STRUCTURE
//  Package dbg_axi_pkg: state enum, RESP_OKAY/EXOKAY/SLVERR/DECERR localparams,
//   DBG_ADDR_W=32, DBG_DATA_W=32.
//  Single module. No sub-module; the watchdog is an inline counter.
// TESTING
//  1 write 0x0/0x1, slave awready+wready same cycle, bresp=0 -> one aw/w handshake,
//    rsp_resp=0, rsp_timeout=0, rsp_rdata=0.
//  2 write, slave wready 3 cycles before awready -> wvalid drops after its handshake,
//    awvalid held until its own handshake, exactly one bready beat.
//  3 read 0x4, slave rdata=0x89abcdef, rresp=0 -> rsp_rdata=0x89abcdef,
//    rsp_valid held 5 cycles while rsp_ready=0.
//  4 read, slave never asserts arready, TMO_LIMIT=16 -> arvalid drops at count 16,
//    rsp_resp=2'b10, rsp_timeout=1; a late rvalid is not accepted.
//  5 read, slave rresp=2'b11 -> rsp_resp=2'b11, rsp_timeout=0.
//    Then an immediate write command is accepted only after the IDLE cycle.
//  6 axi_aresetn low during WR_RESP -> all valids/readies 0 the same cycle;
//    after release cmd_ready=1 and no rsp_valid is produced.

Source files
------------

// File: rtl/dbg_axi_pkg.sv
// Shared types and constants for the AXI4-Lite debug initiator.
package dbg_axi_pkg;

    localparam int DBG_ADDR_W = 32;
    localparam int DBG_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } dbg_state_e;

endpackage

// File: rtl/axi_lite_dbg_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one read or write on the
// bus, one response out. A saturating watchdog abandons any stalled AXI phase.
module axi_lite_dbg_master
    import dbg_axi_pkg::*;
#(
    parameter int               TMO_W     = 16,
    parameter logic [TMO_W-1:0] TMO_LIMIT = {TMO_W{1'b1}}
) (
    input  logic                  axi_clk,
    input  logic                  axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [DBG_ADDR_W-1:0] cmd_addr,
    input  logic [DBG_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DBG_DATA_W-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DBG_ADDR_W-1:0] m_axi_awaddr,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [DBG_DATA_W-1:0] m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    input  logic [1:0]            m_axi_bresp,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [DBG_ADDR_W-1:0] m_axi_araddr,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [DBG_DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp
);

    dbg_state_e            state_q, state_d;
    logic                  cmd_rdy_q, cmd_rdy_d;
    logic                  aw_vld_q, aw_vld_d;
    logic                  w_vld_q, w_vld_d;
    logic                  b_rdy_q, b_rdy_d;
    logic                  ar_vld_q, ar_vld_d;
    logic                  r_rdy_q, r_rdy_d;
    logic [DBG_ADDR_W-1:0] addr_q, addr_d;
    logic [DBG_DATA_W-1:0] wdata_q, wdata_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [DBG_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_tmo_q, rsp_tmo_d;
    logic [TMO_W-1:0]      cnt_q, cnt_d;

    logic tmo_hit, abort, aw_hs, w_hs, counting;

    assign tmo_hit  = (cnt_q == TMO_LIMIT);
    assign aw_hs    = aw_vld_q & m_axi_awready;
    assign w_hs     = w_vld_q & m_axi_wready;
    assign counting = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                      (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);

    always_comb begin
        state_d     = state_q;
        cmd_rdy_d   = cmd_rdy_q;
        aw_vld_d    = aw_vld_q;
        w_vld_d     = w_vld_q;
        b_rdy_d     = b_rdy_q;
        ar_vld_d    = ar_vld_q;
        r_rdy_d     = r_rdy_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_vld_d   = rsp_vld_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_tmo_d   = rsp_tmo_q;
        abort       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_rdy_d = 1'b1;
                if (cmd_valid && cmd_rdy_q) begin
                    cmd_rdy_d = 1'b0;
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    if (cmd_wr) begin
                        state_d  = ST_WR_REQ;
                        aw_vld_d = 1'b1;
                        w_vld_d  = 1'b1;
                    end else begin
                        state_d  = ST_RD_REQ;
                        ar_vld_d = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                // AW and W retire independently; any handshake this cycle defers expiry
                aw_vld_d = aw_vld_q & ~m_axi_awready;
                w_vld_d  = w_vld_q & ~m_axi_wready;
                if (!aw_vld_d && !w_vld_d) begin
                    state_d = ST_WR_RESP;
                    b_rdy_d = 1'b1;
                end else if (tmo_hit && !aw_hs && !w_hs) begin
                    abort = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (b_rdy_q && m_axi_bvalid) begin
                    state_d     = ST_RSP;
                    b_rdy_d     = 1'b0;
                    rsp_vld_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi_bresp;
                    rsp_tmo_d   = 1'b0;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (ar_vld_q && m_axi_arready) begin
                    state_d  = ST_RD_DATA;
                    ar_vld_d = 1'b0;
                    r_rdy_d  = 1'b1;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (r_rdy_q && m_axi_rvalid) begin
                    state_d     = ST_RSP;
                    r_rdy_d     = 1'b0;
                    rsp_vld_d   = 1'b1;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_tmo_d   = 1'b0;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d   = ST_IDLE;
                    rsp_vld_d = 1'b0;
                    cmd_rdy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abandoned access: every channel goes quiet so late beats are never taken
        if (abort) begin
            state_d     = ST_RSP;
            aw_vld_d    = 1'b0;
            w_vld_d     = 1'b0;
            b_rdy_d     = 1'b0;
            ar_vld_d    = 1'b0;
            r_rdy_d     = 1'b0;
            rsp_vld_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_resp_d  = RESP_SLVERR;
            rsp_tmo_d   = 1'b1;
        end

        if (state_d != state_q)
            cnt_d = '0;
        else if (counting && !tmo_hit)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge axi_clk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= ST_IDLE;
            cmd_rdy_q   <= 1'b0;
            aw_vld_q    <= 1'b0;
            w_vld_q     <= 1'b0;
            b_rdy_q     <= 1'b0;
            ar_vld_q    <= 1'b0;
            r_rdy_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            rsp_tmo_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_rdy_q   <= cmd_rdy_d;
            aw_vld_q    <= aw_vld_d;
            w_vld_q     <= w_vld_d;
            b_rdy_q     <= b_rdy_d;
            ar_vld_q    <= ar_vld_d;
            r_rdy_q     <= r_rdy_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_tmo_q   <= rsp_tmo_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready     = cmd_rdy_q;
    assign rsp_valid     = rsp_vld_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_tmo_q;
    assign m_axi_awvalid = aw_vld_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_wvalid  = w_vld_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_bready  = b_rdy_q;
    assign m_axi_arvalid = ar_vld_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_rready  = r_rdy_q;

endmodule

// File: tb/tb_axi_lite_dbg_master.sv
// Randomised bench: a behavioural AXI-Lite slave answers the bus, a reference
// memory predicts every response, and a separate monitor scores rsp_* beats.
module tb_axi_lite_dbg_master;

    localparam int TMO = 16;

    logic        axi_clk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        m_axi_awvalid, m_axi_awready = 1'b0;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_wvalid, m_axi_wready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid = 1'b0, m_axi_bready;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_arvalid, m_axi_arready = 1'b0;
    logic [31:0] m_axi_araddr;
    logic        m_axi_rvalid = 1'b0, m_axi_rready;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;

    always #5 axi_clk = ~axi_clk;

    axi_lite_dbg_master #(.TMO_W(16), .TMO_LIMIT(16'd16)) dut (
        .axi_clk(axi_clk), .axi_aresetn(axi_aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
        int          hold;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] slave_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic set_rdy(input int ch, input logic r);
        case (ch)
            0: m_axi_awready = r;
            1: m_axi_wready  = r;
            default: m_axi_arready = r;
        endcase
    endtask

    function automatic logic get_vld(input int ch);
        case (ch)
            0: return m_axi_awvalid;
            1: return m_axi_wvalid;
            default: return m_axi_arvalid;
        endcase
    endfunction

    // Address/data phase of the slave. ch 0=AW 1=W 2=AR; dly<0 means never ready.
    task automatic slave_req(input int ch, input int dly, output bit done, output logic [31:0] val);
        bit seen = 0, hs, v;
        int hi = 0;
        done = 0;
        val  = '0;
        for (int c = 0; c < TMO + 8; c++) begin
            v = get_vld(ch);
            if (seen && !v) break;
            if (v) begin seen = 1; hi++; end
            set_rdy(ch, dly >= 0 && c >= dly);
            hs  = v && dly >= 0 && c >= dly;
            val = (ch == 0) ? m_axi_awaddr : (ch == 1) ? m_axi_wdata : m_axi_araddr;
            tick();
            if (hs) begin
                done = 1;
                set_rdy(ch, 1'b0);
                chk($sformatf("valid_drop_ch%0d", ch), {31'd0, get_vld(ch)}, 32'd0);
                break;
            end
        end
        set_rdy(ch, 1'b0);
        if (dly >= 0) chk($sformatf("handshake_ch%0d", ch), {31'd0, done}, 32'd1);
        else          chk($sformatf("wdog_valid_cycles_ch%0d", ch), hi, TMO + 1);
    endtask

    // Response phase: B for writes, R for reads.
    task automatic slave_rsp(input bit wr, input int dly, input logic [1:0] resp,
                             input logic [31:0] data, output bit done);
        bit hs, rdy, vld;
        int hi = 0;
        done = 0;
        for (int c = 0; c < TMO + 8; c++) begin
            rdy = wr ? m_axi_bready : m_axi_rready;
            if (hi > 0 && !rdy) break;
            if (rdy) hi++;
            vld = dly >= 0 && c >= dly;
            if (wr) begin m_axi_bvalid = vld; m_axi_bresp = resp; end
            else    begin m_axi_rvalid = vld; m_axi_rresp = resp; m_axi_rdata = data; end
            hs = vld && rdy;
            tick();
            if (hs) begin
                done = 1;
                m_axi_bvalid = 1'b0;
                m_axi_rvalid = 1'b0;
                chk(wr ? "bready_one_beat" : "rready_one_beat",
                    {31'd0, wr ? m_axi_bready : m_axi_rready}, 32'd0);
                break;
            end
        end
        m_axi_bvalid = 1'b0;
        m_axi_rvalid = 1'b0;
        if (dly >= 0) chk(wr ? "b_handshake" : "r_handshake", {31'd0, done}, 32'd1);
        else          chk(wr ? "wdog_bready_cycles" : "wdog_rready_cycles", hi, TMO + 1);
    endtask

    task automatic late_probe();
        m_axi_bvalid = 1'b1;
        m_axi_rvalid = 1'b1;
        repeat (3) begin
            tick();
            chk("late_bready", {31'd0, m_axi_bready}, 32'd0);
            chk("late_rready", {31'd0, m_axi_rready}, 32'd0);
        end
        m_axi_bvalid = 1'b0;
        m_axi_rvalid = 1'b0;
    endtask

    task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        bit hs = 0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
        for (int c = 0; c < 300; c++) begin
            hs = cmd_ready;
            tick();
            if (hs) break;
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", {31'd0, hs}, 32'd1);
        if (wr) chk("cmd_to_aw_w_valid", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
        else    chk("cmd_to_ar_valid", {30'd0, m_axi_awvalid, m_axi_arvalid}, 32'd1);
    endtask

    // Write delays: d0=AW d1=W d2=B. Read delays: d0=AR d2=R. Negative = never.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int d0, input int d1, input int d2,
                           input logic [1:0] resp, input int hold);
        exp_t e;
        bit tmo, da, dw, dr;
        logic [31:0] aa, wd, rdat;
        tmo = (d0 < 0) || (d2 < 0) || (wr && d1 < 0);
        e.tmo  = tmo;
        e.resp = tmo ? 2'b10 : resp;
        e.rdata = (wr || tmo) ? 32'd0 : (ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr));
        e.hold = hold;
        if (wr && d0 >= 0 && d1 >= 0) ref_mem[addr] = wdata;
        exp_q.push_back(e);
        issue_cmd(wr, addr, wdata);
        if (wr) begin
            fork
                slave_req(0, d0, da, aa);
                slave_req(1, d1, dw, wd);
            join
            if (da) chk("awaddr", aa, addr);
            if (dw) chk("wdata", wd, wdata);
            if (da && dw) begin
                slave_mem[aa] = wd;
                slave_rsp(1'b1, d2, resp, 32'd0, dr);
            end
        end else begin
            slave_req(2, d0, da, aa);
            if (da) begin
                chk("araddr", aa, addr);
                rdat = slave_mem.exists(aa) ? slave_mem[aa] : dflt(aa);
                slave_rsp(1'b0, d2, resp, rdat, dr);
            end
        end
        if (tmo) late_probe();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valids"}, {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                               rsp_valid, rsp_timeout, cmd_ready}, 32'd0);
        chk({tag, "_readies"}, {30'd0, m_axi_bready, m_axi_rready}, 32'd0);
        chk({tag, "_rsp_payload"}, rsp_rdata | {30'd0, rsp_resp}, 32'd0);
        chk({tag, "_addr_data"}, m_axi_awaddr | m_axi_araddr | m_axi_wdata, 32'd0);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && !rsp_valid) begin ok = 1; break; end
            tick();
        end
        chk("drain_responses", {31'd0, ok}, 32'd1);
    endtask

    // Response monitor: independent of the stimulus thread.
    initial begin : monitor
        int          w = 0;
        bit          pend = 0;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        logic        s_tmo;
        exp_t        e;
        forever begin
            tick();
            if (!axi_aresetn) begin
                rsp_ready = 1'b0; w = 0; pend = 0;
                continue;
            end
            if (pend) begin
                chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
                pend = 0;
                rsp_ready = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                chk("cmd_ready_low_in_rsp", {31'd0, cmd_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                    rsp_ready = 1'b1; pend = 1;
                end else begin
                    if (w == 0) begin
                        s_rdata = rsp_rdata; s_resp = rsp_resp; s_tmo = rsp_timeout;
                    end else begin
                        chk("rsp_stable", {rsp_rdata ^ s_rdata} | {29'd0, rsp_timeout ^ s_tmo,
                            rsp_resp ^ s_resp}, 32'd0);
                    end
                    if (w >= exp_q[0].hold) begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
                        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.tmo});
                        rsp_ready = 1'b1; pend = 1; w = 0;
                    end else begin
                        rsp_ready = 1'b0; w++;
                    end
                end
            end
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not complete, n_chk=%0d", n_chk);
        $fatal(1, "global timeout");
    end

    initial begin : stim
        bit          wr, dr;
        int          d0, d1, d2, pick;
        logic [31:0] a, wd;
        logic [31:0] aa, wv;
        bit          da, dw;

        tick(); tick();
        chk_all_zero("reset");
        axi_aresetn = 1'b1;
        tick();
        chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        run_txn(1'b1, 32'h0, 32'h1, 0, 0, 0, 2'b00, 0);
        run_txn(1'b1, 32'h10, 32'hCAFE_0010, 3, 0, 1, 2'b00, 1);
        slave_mem[32'h4] = 32'h89AB_CDEF;
        ref_mem[32'h4]   = 32'h89AB_CDEF;
        run_txn(1'b0, 32'h4, 32'h0, 0, 0, 1, 2'b00, 5);
        run_txn(1'b0, 32'h8, 32'h0, -1, 0, 0, 2'b00, 1);
        run_txn(1'b0, 32'hC, 32'h0, 1, 0, 0, 2'b11, 2);
        run_txn(1'b1, 32'h14, 32'h1234_5678, 0, 1, 0, 2'b10, 0);
        run_txn(1'b1, 32'h18, 32'h0BAD_F00D, 0, 0, -1, 2'b00, 0);
        run_txn(1'b1, 32'h1C, 32'h0000_0F0F, 0, -1, 0, 2'b00, 1);
        run_txn(1'b0, 32'h10, 32'h0, 0, 0, -1, 2'b00, 0);
        run_txn(1'b0, 32'h10, 32'h0, 2, 0, 2, 2'b01, 3);

        for (int i = 0; i < 40; i++) begin
            wr = $urandom_range(0, 1) == 1;
            a  = 32'($urandom_range(0, 15)) << 2;
            wd = $urandom;
            d0 = $urandom_range(0, 4);
            d1 = $urandom_range(0, 4);
            d2 = $urandom_range(0, 4);
            if ($urandom_range(0, 9) == 0) begin
                pick = $urandom_range(0, 2);
                if (pick == 0) d0 = -1;
                else if (pick == 1 && wr) d1 = -1;
                else d2 = -1;
            end
            run_txn(wr, a, wd, d0, d1, d2, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

        wait_idle();
        issue_cmd(1'b1, 32'h40, 32'hDEAD_BEEF);
        fork
            slave_req(0, 0, da, aa);
            slave_req(1, 1, dw, wv);
        join
        slave_mem[aa] = wv;
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        tick();
        chk("wr_resp_bready", {31'd0, m_axi_bready}, 32'd1);
        axi_aresetn = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick(); tick();
        axi_aresetn = 1'b1;
        tick();
        chk("cmd_ready_after_midreset", {31'd0, cmd_ready}, 32'd1);
        repeat (10) begin
            tick();
            chk("no_rsp_after_midreset", {31'd0, rsp_valid}, 32'd0);
        end

        run_txn(1'b0, 32'h40, 32'h0, 0, 0, 0, 2'b00, 1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
